// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matrix multiplier: C = A(ROWS x K) * B(K x COLS).
// Latency: first result row ROWS+COLS-1 cycles after the last operand beat, then one row per accepted cycle.
// Backpressure: in_ready only in FEED (bubbles allowed); result rows held stable while out_ready is low.
module systolic_mm_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_MAX      = 16,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [$clog2(K_MAX+1)-1:0]               k_len,
    input  logic                                     signed_mode,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]               a_col,
    input  logic [COLS*DATA_WIDTH-1:0]               b_row,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [COLS*ACC_WIDTH-1:0]                out_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
    output logic                                     busy,
    output logic                                     done
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(K_MAX + ROWS + COLS + 1);
    localparam int PW = 2 * DATA_WIDTH + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_FLUSH, ST_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [KW-1:0]   klen_q, klen_d;
    logic            smode_q, smode_d;
    logic            done_q, done_d;
    logic            clr_acc;
    logic            accept;

    // Operand taps seen by each PE: {valid, data}
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH:0] a_tap;
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH:0] b_tap;
    logic [ROWS-1:0][COLS*ACC_WIDTH-1:0]     acc_rows;

    // Exact product of the (optionally sign-extended) operands, resized to the accumulator width.
    function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b,
                                                     input logic              sm);
        logic signed [PW-1:0] p;
        p = $signed({sm & a[DATA_WIDTH-1], a}) * $signed({sm & b[DATA_WIDTH-1], b});
        return ACC_WIDTH'(p);
    endfunction

    // Control state, counters and per-pass configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            klen_q  <= '0;
            smode_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            klen_q  <= klen_d;
            smode_q <= smode_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        klen_d    = klen_q;
        smode_d   = smode_q;
        done_d    = 1'b0;
        clr_acc   = 1'b0;
        in_ready  = (state_q == ST_FEED);
        out_valid = (state_q == ST_DRAIN);
        busy      = (state_q != ST_IDLE);
        accept    = in_valid & (state_q == ST_FEED);
        out_data  = '0;
        if (state_q == ST_DRAIN) out_data = acc_rows[row_q];
        unique case (state_q)
            ST_IDLE: begin
                if (start && (k_len != '0) && (k_len <= KW'(K_MAX))) begin
                    klen_d  = k_len;
                    smode_d = signed_mode;
                    cnt_d   = '0;
                    clr_acc = 1'b1;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (in_valid) begin
                    if (cnt_q == CW'(klen_q) - CW'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                // Last beat reaches PE(ROWS-1,COLS-1) ROWS+COLS-1 edges after acceptance
                if (cnt_q == CW'(ROWS + COLS - 2)) begin
                    cnt_d   = '0;
                    row_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_row_idx = row_q;
    assign done        = done_q;

    // Row i: first i stages are input skew, the next COLS stages are the PE operand registers moving right
    for (genvar i = 0; i < ROWS; i++) begin : g_arow
        logic [DATA_WIDTH:0] ch_q [i+COLS];
        // Shift A operand with its valid bit one stage per cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d < i + COLS; d++) ch_q[d] <= '0;
            end else begin
                ch_q[0] <= {accept, a_col[i*DATA_WIDTH +: DATA_WIDTH]};
                for (int d = 1; d < i + COLS; d++) ch_q[d] <= ch_q[d-1];
            end
        end
        for (genvar j = 0; j < COLS; j++) begin : g_tap
            assign a_tap[i][j] = ch_q[i+j];
        end
    end

    // Column j: first j stages are input skew, the next ROWS stages are the PE operand registers moving down
    for (genvar j = 0; j < COLS; j++) begin : g_bcol
        logic [DATA_WIDTH:0] ch_q [j+ROWS];
        // Shift B operand with its valid bit one stage per cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d < j + ROWS; d++) ch_q[d] <= '0;
            end else begin
                ch_q[0] <= {accept, b_row[j*DATA_WIDTH +: DATA_WIDTH]};
                for (int d = 1; d < j + ROWS; d++) ch_q[d] <= ch_q[d-1];
            end
        end
        for (genvar i = 0; i < ROWS; i++) begin : g_tap
            assign b_tap[i][j] = ch_q[i+j];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_pe_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe
            logic [ACC_WIDTH-1:0] acc_q;
            // Accumulate only when both operands are real beats, so bubbles never disturb the sum
            always_ff @(posedge clk) begin
                if (rst || clr_acc) begin
                    acc_q <= '0;
                end else if (a_tap[i][j][DATA_WIDTH] && b_tap[i][j][DATA_WIDTH]) begin
                    acc_q <= acc_q + mul_ext(a_tap[i][j][DATA_WIDTH-1:0],
                                             b_tap[i][j][DATA_WIDTH-1:0], smode_q);
                end
            end
            assign acc_rows[i][j*ACC_WIDTH +: ACC_WIDTH] = acc_q;
        end
    end

endmodule
